// File: rtl/usb1bd_frame_timer.sv
// USB1 device SOF/frame timing engine: half-microsecond tick, time since SOF,
// SOF lock tracking, synthesised SOFs on miss and frame continuity checking.
module usb1bd_frame_timer #(
    parameter int HMS_W    = 8,
    parameter int SOFT_W   = 12,
    parameter int LOCK_CNT = 2,
    parameter int MISS_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HMS_W-1:0]  cfg_max_hms,
    input  logic [SOFT_W-1:0] cfg_frame_len,
    input  logic [SOFT_W-1:0] cfg_frame_tol,
    input  logic              cfg_miss_clr,
    input  logic              sof_valid,
    input  logic [10:0]       sof_frame_no,
    output logic              hms_tick,
    output logic [10:0]       frame_no,
    output logic [SOFT_W-1:0] sof_time,
    output logic              sof_pulse,
    output logic              sof_synth,
    output logic              sof_locked,
    output logic              frame_err,
    output logic [7:0]        sof_miss_cnt,
    output logic [31:0]       frm_nat
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        S_UNLOCK  = 2'd0,
        S_LOCKING = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sof;
    logic [10:0]       r_fno;
    logic [HMS_W-1:0]  r_hms_cnt;
    logic              r_hms_tick;
    logic [SOFT_W-1:0] r_sof_time;
    logic [GW-1:0]     r_good;
    logic [MW-1:0]     r_miss_run;
    logic [10:0]       r_frame_no;
    logic              r_pulse;
    logic              r_synth;
    logic              r_err;
    logic              r_locked;
    logic [7:0]        r_miss_cnt;

    state_t            w_state_nx;
    logic [GW-1:0]     w_good_nx;
    logic [MW-1:0]     w_miss_run_nx;
    logic [10:0]       w_frame_no_nx;
    logic              w_pulse_nx;
    logic              w_synth_nx;
    logic              w_err_nx;
    logic [10:0]       w_fno_inc;
    logic              w_sof_ev;
    logic [SOFT_W:0]   w_lo_x;
    logic [SOFT_W:0]   w_hi_x;
    logic [SOFT_W-1:0] w_lo;
    logic [SOFT_W-1:0] w_hi;
    logic              w_in_win;
    logic              w_deadline;

    // Acceptance window, clamped at both ends of the sof_time range
    always_comb begin
        w_lo_x     = {1'b0, cfg_frame_len} - {1'b0, cfg_frame_tol};
        w_hi_x     = {1'b0, cfg_frame_len} + {1'b0, cfg_frame_tol};
        w_lo       = w_lo_x[SOFT_W] ? '0 : w_lo_x[SOFT_W-1:0];
        w_hi       = w_hi_x[SOFT_W] ? '1 : w_hi_x[SOFT_W-1:0];
        w_in_win   = (r_sof_time >= w_lo) && (r_sof_time <= w_hi);
        w_deadline = (r_sof_time > w_hi) && r_hms_tick;
        w_fno_inc  = r_frame_no + 11'd1;
    end

    // Lock FSM next state and per-frame outputs; a real SOF beats a deadline
    always_comb begin
        w_state_nx    = r_state;
        w_good_nx     = r_good;
        w_miss_run_nx = r_miss_run;
        w_frame_no_nx = r_frame_no;
        w_pulse_nx    = 1'b0;
        w_synth_nx    = 1'b0;
        w_err_nx      = 1'b0;
        case (r_state)
            S_UNLOCK: begin
                if (r_sof) begin
                    w_frame_no_nx = r_fno;
                    w_pulse_nx    = 1'b1;
                    w_good_nx     = GW'(1);
                    w_miss_run_nx = '0;
                    w_state_nx    = (LOCK_CNT == 1) ? S_LOCKED : S_LOCKING;
                end
            end
            S_LOCKING: begin
                if (r_sof) begin
                    w_frame_no_nx = r_fno;
                    w_pulse_nx    = 1'b1;
                    if (w_in_win) begin
                        w_good_nx = r_good + GW'(1);
                        if (int'(r_good) + 1 >= LOCK_CNT)
                            w_state_nx = S_LOCKED;
                    end else begin
                        w_good_nx = GW'(1);
                    end
                end else if (w_deadline) begin
                    w_state_nx = S_UNLOCK;
                    w_good_nx  = '0;
                end
            end
            S_LOCKED: begin
                if (r_sof) begin
                    w_frame_no_nx = r_fno;
                    w_pulse_nx    = 1'b1;
                    w_miss_run_nx = '0;
                    w_err_nx      = (r_fno != w_fno_inc) || !w_in_win;
                    if (!w_in_win) begin
                        w_state_nx = S_LOCKING;
                        w_good_nx  = GW'(1);
                    end
                end else if (w_deadline) begin
                    w_frame_no_nx = w_fno_inc;
                    w_pulse_nx    = 1'b1;
                    w_synth_nx    = 1'b1;
                    if (int'(r_miss_run) + 1 >= MISS_MAX) begin
                        w_state_nx    = S_UNLOCK;
                        w_good_nx     = '0;
                        w_miss_run_nx = '0;
                    end else begin
                        w_miss_run_nx = r_miss_run + MW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_UNLOCK;
                w_good_nx  = '0;
            end
        endcase
        w_sof_ev = r_sof | w_synth_nx;
    end

    // FSM state, frame tracking and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_UNLOCK;
            r_sof      <= 1'b0;
            r_fno      <= '0;
            r_good     <= '0;
            r_miss_run <= '0;
            r_frame_no <= '0;
            r_pulse    <= 1'b0;
            r_synth    <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sof      <= sof_valid;
            r_fno      <= sof_frame_no;
            r_good     <= w_good_nx;
            r_miss_run <= w_miss_run_nx;
            r_frame_no <= w_frame_no_nx;
            r_pulse    <= w_pulse_nx;
            r_synth    <= w_synth_nx;
            r_err      <= w_err_nx;
            r_locked   <= (w_state_nx == S_LOCKED);
        end
    end

    // Tick divider and saturating time-since-SOF, both restarted by any SOF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hms_cnt  <= '0;
            r_hms_tick <= 1'b0;
            r_sof_time <= '0;
        end else begin
            r_hms_tick <= (r_hms_cnt == cfg_max_hms);
            if (w_sof_ev || r_hms_cnt == cfg_max_hms)
                r_hms_cnt <= '0;
            else
                r_hms_cnt <= r_hms_cnt + HMS_W'(1);
            if (w_sof_ev)
                r_sof_time <= '0;
            else if (r_hms_tick && r_sof_time != '1)
                r_sof_time <= r_sof_time + SOFT_W'(1);
        end
    end

    // Saturating miss counter; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_miss_cnt <= '0;
        else if (cfg_miss_clr)
            r_miss_cnt <= '0;
        else if (w_synth_nx && r_miss_cnt != 8'hFF)
            r_miss_cnt <= r_miss_cnt + 8'd1;
    end

    assign hms_tick     = r_hms_tick;
    assign frame_no     = r_frame_no;
    assign sof_time     = r_sof_time;
    assign sof_pulse    = r_pulse;
    assign sof_synth    = r_synth;
    assign sof_locked   = r_locked;
    assign frame_err    = r_err;
    assign sof_miss_cnt = r_miss_cnt;
    assign frm_nat      = {4'h0, r_locked, r_frame_no, 16'(r_sof_time)};

endmodule

// File: tb/tb_usb1bd_frame_timer.sv
// Directed bench for usb1bd_frame_timer: tick, lock, synthesis, wrap,
// discontinuity, early SOF, collision, miss clear and saturation.
module tb_usb1bd_frame_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_max_hms;
    logic [11:0] cfg_frame_len;
    logic [11:0] cfg_frame_tol;
    logic        cfg_miss_clr;
    logic        sof_valid;
    logic [10:0] sof_frame_no;

    logic        hms_tick, sof_pulse, sof_synth, sof_locked, frame_err;
    logic [10:0] frame_no;
    logic [11:0] sof_time;
    logic [7:0]  sof_miss_cnt;
    logic [31:0] frm_nat;

    logic        s_tick, s_pulse, s_synth, s_locked, s_err;
    logic [10:0] s_frame_no;
    logic [11:0] s_time;
    logic [7:0]  s_miss;
    logic [31:0] s_nat;

    int checks = 0;
    int errors = 0;

    usb1bd_frame_timer u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_max_hms(cfg_max_hms), .cfg_frame_len(cfg_frame_len),
        .cfg_frame_tol(cfg_frame_tol), .cfg_miss_clr(cfg_miss_clr),
        .sof_valid(sof_valid), .sof_frame_no(sof_frame_no),
        .hms_tick(hms_tick), .frame_no(frame_no), .sof_time(sof_time),
        .sof_pulse(sof_pulse), .sof_synth(sof_synth),
        .sof_locked(sof_locked), .frame_err(frame_err),
        .sof_miss_cnt(sof_miss_cnt), .frm_nat(frm_nat)
    );

    usb1bd_frame_timer #(.MISS_MAX(400)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .cfg_max_hms(cfg_max_hms), .cfg_frame_len(cfg_frame_len),
        .cfg_frame_tol(cfg_frame_tol), .cfg_miss_clr(cfg_miss_clr),
        .sof_valid(sof_valid), .sof_frame_no(sof_frame_no),
        .hms_tick(s_tick), .frame_no(s_frame_no), .sof_time(s_time),
        .sof_pulse(s_pulse), .sof_synth(s_synth),
        .sof_locked(s_locked), .frame_err(s_err),
        .sof_miss_cnt(s_miss), .frm_nat(s_nat)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle SOF, returns once the DUT has acted on it
    task automatic do_sof(input logic [10:0] fno);
        sof_valid    = 1'b1;
        sof_frame_no = fno;
        step(1);
        sof_valid    = 1'b0;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        cfg_max_hms   = 8'd5;
        cfg_frame_len = 12'd20;
        cfg_frame_tol = 12'd2;
        cfg_miss_clr  = 1'b0;
        sof_valid     = 1'b0;
        sof_frame_no  = '0;
        step(2);
        chk("rst_tick", hms_tick, 0);
        chk("rst_fno", frame_no, 0);
        chk("rst_time", sof_time, 0);
        chk("rst_lock", sof_locked, 0);
        chk("rst_miss", sof_miss_cnt, 0);
        chk("rst_pulse", sof_pulse, 0);
        chk("rst_nat", frm_nat, 0);

        rst_n = 1'b1;
        step(5);
        chk("tick_pre", hms_tick, 0);
        chk("time_pre", sof_time, 0);
        step(1);
        chk("tick_1", hms_tick, 1);
        step(1);
        chk("tick_off", hms_tick, 0);
        chk("time_1", sof_time, 1);
        step(5);
        chk("tick_2", hms_tick, 1);
        step(1);
        chk("time_2", sof_time, 2);
        chk("nat_time", frm_nat, 32'd2);
        chk("lock_idle", sof_locked, 0);

        rst_n = 1'b0;
        cfg_max_hms = 8'd0;
        step(1);
        rst_n = 1'b1;
        step(3);
        do_sof(11'd10);
        chk("l1_pulse", sof_pulse, 1);
        chk("l1_fno", frame_no, 10);
        chk("l1_lock", sof_locked, 0);
        chk("l1_time", sof_time, 0);
        step(19);
        do_sof(11'd11);
        chk("l2_lock", sof_locked, 1);
        chk("l2_fno", frame_no, 11);
        chk("l2_err", frame_err, 0);
        chk("l2_nat", frm_nat, {4'h0, 1'b1, 11'd11, 16'd0});

        step(19);
        do_sof(11'd12);
        chk("cont_err", frame_err, 0);
        chk("cont_lock", sof_locked, 1);
        step(19);
        do_sof(11'd17);
        chk("disc_err", frame_err, 1);
        chk("disc_fno", frame_no, 17);
        chk("disc_lock", sof_locked, 1);
        step(1);
        chk("disc_err_off", frame_err, 0);

        step(8);
        do_sof(11'd18);
        chk("early_err", frame_err, 1);
        chk("early_lock", sof_locked, 0);
        chk("early_time", sof_time, 0);
        chk("early_fno", frame_no, 18);
        step(19);
        do_sof(11'd19);
        chk("relock", sof_locked, 1);

        step(19);
        do_sof(11'd2047);
        chk("f2047", frame_no, 2047);
        chk("f2047_err", frame_err, 1);
        step(23);
        chk("pre_synth", sof_pulse, 0);
        step(1);
        chk("s1_pulse", sof_pulse, 1);
        chk("s1_synth", sof_synth, 1);
        chk("s1_wrap", frame_no, 0);
        chk("s1_miss", sof_miss_cnt, 1);
        chk("s1_lock", sof_locked, 1);
        chk("s1_time", sof_time, 0);
        step(24);
        chk("s2_fno", frame_no, 1);
        chk("s2_miss", sof_miss_cnt, 2);
        step(24);
        chk("s3_synth", sof_synth, 1);
        chk("s3_fno", frame_no, 2);
        chk("s3_miss", sof_miss_cnt, 3);
        chk("s3_lock", sof_locked, 0);
        step(30);
        chk("unl_miss", sof_miss_cnt, 3);
        chk("unl_pulse", sof_pulse, 0);

        do_sof(11'd50);
        step(19);
        do_sof(11'd51);
        chk("c_lock", sof_locked, 1);
        step(22);
        do_sof(11'd52);
        chk("col_pulse", sof_pulse, 1);
        chk("col_synth", sof_synth, 0);
        chk("col_miss", sof_miss_cnt, 3);
        chk("col_err", frame_err, 1);
        chk("col_lock", sof_locked, 0);
        chk("col_fno", frame_no, 52);

        step(19);
        do_sof(11'd53);
        chk("m_lock", sof_locked, 1);
        step(23);
        cfg_miss_clr = 1'b1;
        step(1);
        cfg_miss_clr = 1'b0;
        chk("clr_synth", sof_synth, 1);
        chk("clr_miss", sof_miss_cnt, 0);
        chk("clr_fno", frame_no, 54);

        step(5);
        rst_n = 1'b0;
        #1;
        chk("mrst_time", sof_time, 0);
        chk("mrst_lock", sof_locked, 0);
        chk("mrst_fno", frame_no, 0);
        chk("mrst_nat", frm_nat, 0);

        step(1);
        rst_n = 1'b1;
        step(3);
        do_sof(11'd0);
        step(19);
        do_sof(11'd1);
        chk("sat_lock0", s_locked, 1);
        repeat (300) step(24);
        chk("sat_miss", s_miss, 255);
        chk("sat_fno", s_frame_no, 301);
        chk("sat_synth", s_synth, 1);
        chk("sat_lock", s_locked, 1);
        chk("main_lock", sof_locked, 0);
        chk("main_miss", sof_miss_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
